pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 2, register address width.
REQ-002 SHALL have parameter FWD_N, default 3, number of forwarding stages, index 0 = EX (youngest) .. FWD_N-1 (oldest).
REQ-003 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles (1..7).
REQ-004 SHALL have parameter ZERO_REG, default 0; when 1, register address 0 is never forwarded or stalled on.
REQ-005 Ports SHALL be, in order:
  clk  in  1  clock, rising edge;
  reset  in  1  synchronous active-high reset;
  rs, rt  in  REG_AW each  source addresses in ID;
  use_rs, use_rt  in  1 each  ID instruction reads rs / rt;
  halt_id  in  1  HLT in ID;
  dest_flat  in  FWD_N*REG_AW  destination per stage, stage k at [k*REG_AW +: REG_AW];
  regwrite_vec  in  FWD_N  register-write valid per stage;
  load_ex  in  1  load in EX;
  i_hit, d_hit  in  1 each  I-/D-cache hit (d_hit=1 when no D access);
  i_ready, d_ready  in  1 each  refill-done pulses;
  br  in  1  DMA bus request;
  bg  out  1  DMA bus grant;
  stage_we  out  5  write enables {PC,IF/ID,ID/EX,EX/M,M/WB}, bit 4 = PC;
  flush_ex  out  1  insert bubble into ID/EX;
  both_access  out  1  I and D refills outstanding;
  fwd_a, fwd_b  out  $clog2(FWD_N+1) each  forward select, 0 = register file, k+1 = stage k.

Function
REQ-006 Forwarding SHALL be combinational: fwd_a = k+1 for the lowest k with regwrite_vec[k] & dest k == rs & use_rs (excluding rs==0 when ZERO_REG), else 0; fwd_b likewise for rt/use_rt.
REQ-007 Load-use hazard SHALL be load_ex & stage-0 match on a used source (per REQ-006 qualification).
REQ-008 FSM states SHALL be RUN, LOAD_STALL, MISS_I, MISS_D, MISS_BOTH, DMA; state registered, outputs decoded from state and current inputs.
REQ-009 RUN priority: !d_hit -> MISS_BOTH if also !i_hit else MISS_D; else !i_hit -> MISS_I; else load-use -> LOAD_STALL (LOAD_LAT>1) or stay RUN; else br -> DMA; else RUN.
REQ-010 RUN outputs: d miss -> stage_we=00000; i miss -> 00111 with flush_ex=1; load-use -> 00011 with flush_ex=1; else 11111.
REQ-011 LOAD_STALL SHALL hold 00011 with flush_ex=1, count LOAD_LAT-1 cycles with a 3-bit counter, then return to RUN; total stall equals LOAD_LAT cycles.
REQ-012 MISS_I: 00111, flush_ex=1; !d_hit -> MISS_BOTH; i_ready -> RUN with stage_we=11111 that cycle.
REQ-013 MISS_D: 00000; !i_hit -> MISS_BOTH; d_ready -> RUN with 11111 that cycle.
REQ-014 MISS_BOTH: 00000, both_access=1; i_ready and d_ready SHALL be latched in sticky flags; exit to RUN with 11111 in the cycle both (flag or live pulse) are seen; flags clear on exit.
REQ-015 DMA: bg=1; cache hits proceed with 11111; any miss -> 00000 and stays in DMA (bus owned by DMA); br=0 -> RUN, bg=0 from next cycle.
REQ-016 br arriving in any non-RUN state SHALL be deferred until RUN; bg never asserts during MISS_* or LOAD_STALL.
REQ-017 halt_id SHALL force stage_we[4:3]=00, lower bits per state; flush_ex unaffected.

Reset
REQ-018 reset SHALL put state in RUN, counter and sticky flags at 0; while reset is high: stage_we=11111, flush_ex=0, bg=0, both_access=0, fwd_a=fwd_b=0.
REQ-019 reset mid-miss or mid-DMA SHALL abort immediately; bg deasserts in the reset cycle.

Structure
REQ-020 State encodings and stage_we bit positions SHALL live in a shared package/header with opcodes.
REQ-021 Forwarding match SHALL be one sub-module, fwd_select, instantiated twice (rs, rt).

Verification
REQ-022 dest_flat stage0=stage1=2, regwrite_vec=011, rs=2, use_rs=1 -> fwd_a=1; clear bit0 -> fwd_a=2.
REQ-023 ZERO_REG=1, rs=0 matching stage 0 with load_ex=1 -> fwd_a=0, stage_we=11111, no stall.
REQ-024 LOAD_LAT=3, load-use in RUN -> exactly 3 cycles stage_we=00011, flush_ex=1, then 11111.
REQ-025 i miss, d miss 2 cycles later, d_ready at cycle 5, i_ready at cycle 9 -> both_access=1 cycles 2..9, 11111 at cycle 9, RUN at 10.
REQ-026 br during MISS_D -> bg=0 until d_ready; bg=1 cycle after return to RUN; br=0 -> bg=0 next cycle.
REQ-027 reset asserted during DMA with d miss -> same cycle stage_we=11111, bg=0; next state RUN.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state encodings,
// stage write-enable bit positions and the standard stage_we patterns.
package pipeline_stall_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN        = 3'd0,
      ST_LOAD_STALL = 3'd1,
      ST_MISS_I     = 3'd2,
      ST_MISS_D     = 3'd3,
      ST_MISS_BOTH  = 3'd4,
      ST_DMA        = 3'd5
   } state_t;

   // stage_we bit order is {PC, IF/ID, ID/EX, EX/M, M/WB}
   localparam int WE_PC   = 4;
   localparam int WE_IFID = 3;

   localparam logic [4:0] WE_ALL   = 5'b11111;
   localparam logic [4:0] WE_NONE  = 5'b00000;
   localparam logic [4:0] WE_IMISS = 5'b00111;
   localparam logic [4:0] WE_LOAD  = 5'b00011;

   function automatic int sel_width(input int n_stages);
      return $clog2(n_stages + 1);
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_fwd_select.sv
// Forwarding match for one ID source operand: picks the youngest writing stage
// whose destination equals the source, and flags a match in EX for load-use.
module fwd_select
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int REG_AW   = 2,
   parameter int FWD_N    = 3,
   parameter int ZERO_REG = 0,
   parameter int SEL_W    = sel_width(FWD_N)
) (
   input  logic [REG_AW-1:0]       src,
   input  logic                    use_src,
   input  logic [FWD_N*REG_AW-1:0] dest_flat,
   input  logic [FWD_N-1:0]        regwrite_vec,
   output logic [SEL_W-1:0]        sel,
   output logic                    hit_ex
);

   logic             src_ok;
   logic [FWD_N-1:0] match;

   assign src_ok = (ZERO_REG == 0) || (|src);

   generate
      for (genvar gi = 0; gi < FWD_N; gi++) begin : g_match
         assign match[gi] = use_src & src_ok & regwrite_vec[gi] &
                            (dest_flat[gi*REG_AW +: REG_AW] == src);
      end
   endgenerate

   // Scan oldest to youngest so the youngest matching stage wins.
   always_comb begin
      sel = '0;
      for (int k = FWD_N - 1; k >= 0; k--) begin
         if (match[k]) sel = SEL_W'(k + 1);
      end
   end

   assign hit_ex = match[0];

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard/stall controller: operand forwarding, load-use stalls,
// I/D cache miss freezing and DMA bus arbitration.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int REG_AW   = 2,
   parameter int FWD_N    = 3,
   parameter int LOAD_LAT = 1,
   parameter int ZERO_REG = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [REG_AW-1:0]            rs,
   input  logic [REG_AW-1:0]            rt,
   input  logic                         use_rs,
   input  logic                         use_rt,
   input  logic                         halt_id,
   input  logic [FWD_N*REG_AW-1:0]      dest_flat,
   input  logic [FWD_N-1:0]             regwrite_vec,
   input  logic                         load_ex,
   input  logic                         i_hit,
   input  logic                         d_hit,
   input  logic                         i_ready,
   input  logic                         d_ready,
   input  logic                         br,
   output logic                         bg,
   output logic [4:0]                   stage_we,
   output logic                         flush_ex,
   output logic                         both_access,
   output logic [$clog2(FWD_N+1)-1:0]   fwd_a,
   output logic [$clog2(FWD_N+1)-1:0]   fwd_b
);

   localparam int SEL_W = sel_width(FWD_N);

   state_t     state_reg, state_next;
   logic [2:0] cnt_reg, cnt_next;
   logic       i_flag_reg, i_flag_next;
   logic       d_flag_reg, d_flag_next;

   logic [SEL_W-1:0] sel_a, sel_b;
   logic             ex_a, ex_b;
   logic             load_use, i_miss, d_miss, i_seen, d_seen;

   fwd_select #(.REG_AW(REG_AW), .FWD_N(FWD_N), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)) u_fwd_a (
      .src(rs), .use_src(use_rs), .dest_flat(dest_flat), .regwrite_vec(regwrite_vec),
      .sel(sel_a), .hit_ex(ex_a)
   );

   fwd_select #(.REG_AW(REG_AW), .FWD_N(FWD_N), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)) u_fwd_b (
      .src(rt), .use_src(use_rt), .dest_flat(dest_flat), .regwrite_vec(regwrite_vec),
      .sel(sel_b), .hit_ex(ex_b)
   );

   assign load_use = load_ex & (ex_a | ex_b);
   assign i_miss   = ~i_hit;
   assign d_miss   = ~d_hit;
   assign i_seen   = i_flag_reg | i_ready;
   assign d_seen   = d_flag_reg | d_ready;
   assign fwd_a    = reset ? '0 : sel_a;
   assign fwd_b    = reset ? '0 : sel_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_RUN;
         cnt_reg    <= '0;
         i_flag_reg <= 1'b0;
         d_flag_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         i_flag_reg <= i_flag_next;
         d_flag_reg <= d_flag_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      i_flag_next = i_flag_reg;
      d_flag_next = d_flag_reg;
      case (state_reg)
         ST_RUN: begin
            if (d_miss) begin
               state_next  = i_miss ? ST_MISS_BOTH : ST_MISS_D;
               i_flag_next = 1'b0;
               d_flag_next = 1'b0;
            end else if (i_miss) begin
               state_next = ST_MISS_I;
            end else if (load_use) begin
               // The RUN cycle is the first stall cycle; LOAD_STALL covers the rest.
               if (LOAD_LAT > 1) begin
                  state_next = ST_LOAD_STALL;
                  cnt_next   = 3'(LOAD_LAT - 1);
               end
            end else if (br) begin
               state_next = ST_DMA;
            end
         end
         ST_LOAD_STALL: begin
            if (cnt_reg <= 3'd1) state_next = ST_RUN;
            else                 cnt_next   = cnt_reg - 3'd1;
         end
         ST_MISS_I: begin
            if (d_miss) begin
               state_next  = ST_MISS_BOTH;
               i_flag_next = i_ready;
               d_flag_next = 1'b0;
            end else if (i_ready) begin
               state_next = ST_RUN;
            end
         end
         ST_MISS_D: begin
            if (i_miss) begin
               state_next  = ST_MISS_BOTH;
               i_flag_next = 1'b0;
               d_flag_next = d_ready;
            end else if (d_ready) begin
               state_next = ST_RUN;
            end
         end
         ST_MISS_BOTH: begin
            if (i_seen & d_seen) begin
               state_next  = ST_RUN;
               i_flag_next = 1'b0;
               d_flag_next = 1'b0;
            end else begin
               i_flag_next = i_seen;
               d_flag_next = d_seen;
            end
         end
         ST_DMA: begin
            if (!br) state_next = ST_RUN;
         end
         default: state_next = ST_RUN;
      endcase
   end

   always_comb begin
      stage_we    = WE_ALL;
      flush_ex    = 1'b0;
      both_access = 1'b0;
      bg          = 1'b0;
      case (state_reg)
         ST_RUN: begin
            if (d_miss) begin
               stage_we    = WE_NONE;
               both_access = i_miss;
            end else if (i_miss) begin
               stage_we = WE_IMISS;
               flush_ex = 1'b1;
            end else if (load_use) begin
               stage_we = WE_LOAD;
               flush_ex = 1'b1;
            end
         end
         ST_LOAD_STALL: begin
            stage_we = WE_LOAD;
            flush_ex = 1'b1;
         end
         ST_MISS_I: begin
            if (d_miss) begin
               stage_we    = WE_NONE;
               flush_ex    = 1'b1;
               both_access = 1'b1;
            end else if (!i_ready) begin
               stage_we = WE_IMISS;
               flush_ex = 1'b1;
            end
         end
         ST_MISS_D: begin
            if (i_miss) begin
               stage_we    = WE_NONE;
               both_access = 1'b1;
            end else if (!d_ready) begin
               stage_we = WE_NONE;
            end
         end
         ST_MISS_BOTH: begin
            both_access = 1'b1;
            if (!(i_seen & d_seen)) stage_we = WE_NONE;
         end
         ST_DMA: begin
            bg = 1'b1;
            if (i_miss | d_miss) stage_we = WE_NONE;
         end
         default: stage_we = WE_ALL;
      endcase
      if (halt_id) begin
         stage_we[WE_PC]   = 1'b0;
         stage_we[WE_IFID] = 1'b0;
      end
      // Reset overrides everything so an in-flight miss or DMA grant drops at once.
      if (reset) begin
         stage_we    = WE_ALL;
         flush_ex    = 1'b0;
         both_access = 1'b0;
         bg          = 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector bench: the driver queues the expected outputs per cycle and a
// negedge monitor pops and compares them against the controller outputs.
module tb_pipeline_stall_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] rs, rt;
   logic       use_rs, use_rt, halt_id;
   logic [5:0] dest_flat;
   logic [2:0] regwrite_vec;
   logic       load_ex, i_hit, d_hit, i_ready, d_ready, br;
   logic       bg, flush_ex, both_access;
   logic [4:0] stage_we;
   logic [1:0] fwd_a, fwd_b;

   typedef struct packed {
      logic [4:0] we;
      logic       fl;
      logic       ba;
      logic       bg;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   exp_t  sb_q[$];
   string nm_q[$];
   int    vectors = 0;
   int    miscompares = 0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.REG_AW(2), .FWD_N(3), .LOAD_LAT(3), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
      .halt_id(halt_id), .dest_flat(dest_flat), .regwrite_vec(regwrite_vec),
      .load_ex(load_ex), .i_hit(i_hit), .d_hit(d_hit), .i_ready(i_ready),
      .d_ready(d_ready), .br(br), .bg(bg), .stage_we(stage_we), .flush_ex(flush_ex),
      .both_access(both_access), .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t  e;
         string n;
         e = sb_q.pop_front();
         n = nm_q.pop_front();
         vectors++;
         if (stage_we !== e.we || flush_ex !== e.fl || both_access !== e.ba ||
             bg !== e.bg || fwd_a !== e.fa || fwd_b !== e.fb) begin
            miscompares++;
            $display("FAIL %s: got we=%b flush=%b both=%b bg=%b fa=%0d fb=%0d, expected we=%b flush=%b both=%b bg=%b fa=%0d fb=%0d",
                     n, stage_we, flush_ex, both_access, bg, fwd_a, fwd_b,
                     e.we, e.fl, e.ba, e.bg, e.fa, e.fb);
         end else begin
            $display("ok   %s: we=%b flush=%b both=%b bg=%b fa=%0d fb=%0d",
                     n, stage_we, flush_ex, both_access, bg, fwd_a, fwd_b);
         end
      end
   end

   task automatic idle();
      reset = 1'b0; rs = '0; rt = '0; use_rs = 1'b0; use_rt = 1'b0; halt_id = 1'b0;
      dest_flat = '0; regwrite_vec = '0; load_ex = 1'b0; i_hit = 1'b1; d_hit = 1'b1;
      i_ready = 1'b0; d_ready = 1'b0; br = 1'b0;
   endtask

   // Queue the expectation for the inputs currently driven, then advance one cycle.
   task automatic cyc(input string nm, input logic [4:0] we, input logic fl, input logic ba,
                      input logic bgx, input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      e.we = we; e.fl = fl; e.ba = ba; e.bg = bgx; e.fa = fa; e.fb = fb;
      sb_q.push_back(e);
      nm_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Reset state, with a forwarding match present that must stay masked.
      rs = 2'd1; use_rs = 1'b1; dest_flat = {2'd0, 2'd0, 2'd1}; regwrite_vec = 3'b001;
      br = 1'b1; i_hit = 1'b0;
      cyc("reset_0", 5'b11111, 0, 0, 0, 0, 0);
      cyc("reset_1", 5'b11111, 0, 0, 0, 0, 0);
      idle();

      // Forwarding priority.
      rs = 2'd2; use_rs = 1'b1; dest_flat = {2'd0, 2'd2, 2'd2}; regwrite_vec = 3'b011;
      cyc("fwd_a_stage0", 5'b11111, 0, 0, 0, 1, 0);
      regwrite_vec = 3'b010;
      cyc("fwd_a_stage1", 5'b11111, 0, 0, 0, 2, 0);
      rt = 2'd3; use_rt = 1'b1; dest_flat = {2'd3, 2'd2, 2'd2}; regwrite_vec = 3'b100;
      cyc("fwd_b_stage2", 5'b11111, 0, 0, 0, 0, 3);
      use_rt = 1'b0;
      cyc("fwd_b_unused", 5'b11111, 0, 0, 0, 0, 0);
      idle();

      // Register 0 is never forwarded or stalled on.
      rs = 2'd0; use_rs = 1'b1; dest_flat = '0; regwrite_vec = 3'b001; load_ex = 1'b1;
      cyc("zero_reg_0", 5'b11111, 0, 0, 0, 0, 0);
      cyc("zero_reg_1", 5'b11111, 0, 0, 0, 0, 0);
      idle();

      // Load-use with LOAD_LAT=3: three stall cycles, then full advance.
      rt = 2'd1; use_rt = 1'b1; dest_flat = {2'd0, 2'd0, 2'd1}; regwrite_vec = 3'b001; load_ex = 1'b1;
      cyc("load_use_1", 5'b00011, 1, 0, 0, 0, 1);
      idle();
      cyc("load_use_2", 5'b00011, 1, 0, 0, 0, 0);
      cyc("load_use_3", 5'b00011, 1, 0, 0, 0, 0);
      cyc("load_use_done", 5'b11111, 0, 0, 0, 0, 0);

      halt_id = 1'b1;
      cyc("halt_run", 5'b00111, 0, 0, 0, 0, 0);
      idle();

      // Simple I miss.
      i_hit = 1'b0;
      cyc("imiss_0", 5'b00111, 1, 0, 0, 0, 0);
      cyc("imiss_1", 5'b00111, 1, 0, 0, 0, 0);
      i_ready = 1'b1;
      cyc("imiss_ready", 5'b11111, 0, 0, 0, 0, 0);
      idle();
      cyc("imiss_run", 5'b11111, 0, 0, 0, 0, 0);

      // I miss, D miss two cycles later, d_ready at 5, i_ready at 9.
      i_hit = 1'b0;
      cyc("both_c0", 5'b00111, 1, 0, 0, 0, 0);
      cyc("both_c1", 5'b00111, 1, 0, 0, 0, 0);
      d_hit = 1'b0;
      cyc("both_c2", 5'b00000, 1, 1, 0, 0, 0);
      for (int c = 3; c <= 8; c++) begin
         d_ready = (c == 5);
         cyc($sformatf("both_c%0d", c), 5'b00000, 0, 1, 0, 0, 0);
      end
      d_ready = 1'b0; i_ready = 1'b1;
      cyc("both_c9", 5'b11111, 0, 1, 0, 0, 0);
      idle();
      cyc("both_c10", 5'b11111, 0, 0, 0, 0, 0);

      // Bus request during a D miss is deferred until RUN.
      d_hit = 1'b0;
      cyc("dma_dmiss", 5'b00000, 0, 0, 0, 0, 0);
      br = 1'b1;
      cyc("dma_defer_1", 5'b00000, 0, 0, 0, 0, 0);
      cyc("dma_defer_2", 5'b00000, 0, 0, 0, 0, 0);
      d_hit = 1'b1; d_ready = 1'b1;
      cyc("dma_dready", 5'b11111, 0, 0, 0, 0, 0);
      d_ready = 1'b0;
      cyc("dma_run", 5'b11111, 0, 0, 0, 0, 0);
      cyc("dma_grant", 5'b11111, 0, 0, 1, 0, 0);
      d_hit = 1'b0;
      cyc("dma_miss_hold", 5'b00000, 0, 0, 1, 0, 0);
      d_hit = 1'b1; halt_id = 1'b1;
      cyc("dma_halt", 5'b00111, 0, 0, 1, 0, 0);
      halt_id = 1'b0; br = 1'b0;
      cyc("dma_release", 5'b11111, 0, 0, 1, 0, 0);
      cyc("dma_bg_off", 5'b11111, 0, 0, 0, 0, 0);

      // Reset in DMA with a D miss aborts at once.
      br = 1'b1;
      cyc("rst_dma_req", 5'b11111, 0, 0, 0, 0, 0);
      d_hit = 1'b0;
      cyc("rst_dma_miss", 5'b00000, 0, 0, 1, 0, 0);
      reset = 1'b1;
      cyc("rst_dma_abort", 5'b11111, 0, 0, 0, 0, 0);
      reset = 1'b0; d_hit = 1'b1;
      cyc("rst_dma_run", 5'b11111, 0, 0, 0, 0, 0);
      br = 1'b0;
      cyc("rst_dma_regrant", 5'b11111, 0, 0, 1, 0, 0);
      idle();
      cyc("rst_dma_idle", 5'b11111, 0, 0, 0, 0, 0);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending vectors, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
